// File: rtl/nibble_ctrl_pkg.sv
// rtl/nibble_ctrl_pkg.sv - shared constants, FSM state type and helpers for the nibble-serial adder
package nibble_ctrl_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Bitwise incrementer so the controller carries no arithmetic operators of its own.
  function automatic logic [31:0] inc_u32(input logic [31:0] v);
    logic [31:0] r;
    logic        c;
    c = 1'b1;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[i] ^ c;
      c    = v[i] & c;
    end
    return r;
  endfunction

endpackage

// File: rtl/nibble_serial_add_ctrl_if.sv
// rtl/nibble_serial_add_ctrl_if.sv - operand/result handshake bundle for the nibble-serial adder
interface nibble_serial_add_ctrl_if #(parameter int NIBBLES = 4);
  import nibble_ctrl_pkg::*;

  localparam int W = NIBBLE_W * NIBBLES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, busy
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, busy
  );

endinterface

// File: rtl/part2.sv
// rtl/part2.sv - 4-bit ripple-carry adder
module part2 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  always_comb begin : ripple
    logic c;
    c = cin;
    for (int i = 0; i < 4; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// rtl/nibble_serial_add_ctrl.sv - W-bit adder built from one 4-bit ripple slice reused over NIBBLES cycles
module nibble_serial_add_ctrl
  import nibble_ctrl_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input logic                     clk,
  input logic                     rst_n,
  nibble_serial_add_ctrl_if.slave bus
);

  localparam int                W        = NIBBLE_W * NIBBLES;
  localparam int                IDX_W    = idx_width(NIBBLES);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NIBBLES - 1);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                carry_q, carry_d;
  logic [W-1:0]        a_q, a_d;
  logic [W-1:0]        b_q, b_d;
  logic [W-1:0]        sum_q, sum_d;
  logic                cout_q, cout_d;

  logic [NIBBLE_W-1:0] a4, b4, s4;
  logic                cout4;
  logic                last_slice;

  part2 u_slice_add (
    .a    (a4),
    .b    (b4),
    .cin  (carry_q),
    .s    (s4),
    .cout (cout4)
  );

  assign last_slice = (idx_q == LAST_IDX);

  always_comb begin
    a4 = '0;
    b4 = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        a4 = a_q[i*NIBBLE_W +: NIBBLE_W];
        b4 = b_q[i*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.in_valid)  state_d = ST_RUN;
      ST_RUN:  if (last_slice)    state_d = ST_DONE;
      ST_DONE: if (bus.out_ready) state_d = ST_IDLE;
      default:                    state_d = ST_IDLE;
    endcase
  end

  // Operands are only captured in IDLE, so requester activity during RUN/DONE cannot disturb the result.
  always_comb begin
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          carry_d = bus.cin;
          sum_d   = '0;
          idx_d   = '0;
        end
      end
      ST_RUN: begin
        for (int i = 0; i < NIBBLES; i++) begin
          if (idx_q == IDX_W'(i)) sum_d[i*NIBBLE_W +: NIBBLE_W] = s4;
        end
        carry_d = cout4;
        if (last_slice) cout_d = cout4;
        else            idx_d  = IDX_W'(inc_u32(32'(idx_q)));
      end
      default: ;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == ST_IDLE);
    bus.out_valid = (state_q == ST_DONE);
    bus.busy      = (state_q != ST_IDLE);
    bus.sum       = sum_q;
    bus.cout      = cout_q;
  end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// tb/tb_nibble_serial_add_ctrl.sv - randomized bench for nibble_serial_add_ctrl against a transaction-level model
module tb_nibble_serial_add_ctrl;

  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;
  localparam int TO      = 50;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_total = 0;
  int   n_pass  = 0;
  bit   chk_en  = 1'b0;

  nibble_serial_add_ctrl_if #(.NIBBLES(NIBBLES)) bus ();

  nibble_serial_add_ctrl #(.NIBBLES(NIBBLES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: an accepted pair yields A+B+cin after NIBBLES edges, held until taken.
  logic [W-1:0] m_sum   = '0;
  logic         m_cout  = 1'b0;
  logic         m_busy  = 1'b0;
  logic         m_valid = 1'b0;
  logic         m_zero  = 1'b0;
  int           m_cnt   = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy  <= 1'b0;
      m_valid <= 1'b0;
      m_zero  <= 1'b1;
      m_cnt   <= 0;
    end else if (!m_busy) begin
      if (bus.in_valid) begin
        {m_cout, m_sum} <= {1'b0, bus.a} + {1'b0, bus.b} + (W+1)'(bus.cin);
        m_busy <= 1'b1;
        m_zero <= 1'b0;
        m_cnt  <= NIBBLES;
      end
    end else if (!m_valid) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) m_valid <= 1'b1;
    end else if (bus.out_ready) begin
      m_busy  <= 1'b0;
      m_valid <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", 64'(bus.in_ready), 64'(!m_busy));
      chk("busy", 64'(bus.busy), 64'(m_busy));
      chk("out_valid", 64'(bus.out_valid), 64'(m_valid));
      if (m_valid) begin
        chk("sum", 64'(bus.sum), 64'(m_sum));
        chk("cout", 64'(bus.cout), 64'(m_cout));
      end
      if (m_zero) begin
        chk("sum_after_reset", 64'(bus.sum), 64'h0);
        chk("cout_after_reset", 64'(bus.cout), 64'h0);
      end
    end
  end

  task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci, output int waited);
    bus.a        = av;
    bus.b        = bv;
    bus.cin      = ci;
    bus.in_valid = 1'b1;
    waited       = 0;
    while (!bus.in_ready && waited < TO) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= TO) chk("accept_timeout", 64'h1, 64'h0);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < TO) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    if (lat >= TO) chk("valid_timeout", 64'h1, 64'h0);
  endtask

  task automatic take(input int stall, input bit toggle, input bit use_lit,
                      input logic [W-1:0] es, input logic ec);
    logic [W-1:0] s0;
    logic         c0;
    s0 = bus.sum;
    c0 = bus.cout;
    if (use_lit) begin
      chk("lit_sum", 64'(bus.sum), 64'(es));
      chk("lit_cout", 64'(bus.cout), 64'(ec));
      chk("model_lit_sum", 64'(m_sum), 64'(es));
      chk("model_lit_cout", 64'(m_cout), 64'(ec));
    end
    bus.out_ready = 1'b0;
    for (int k = 0; k < stall; k++) begin
      if (toggle) begin
        bus.in_valid = 1'b1;
        bus.a        = W'($urandom);
        bus.b        = W'($urandom);
        bus.cin      = 1'($urandom);
      end
      @(posedge clk);
      @(negedge clk);
      chk("hold_sum", 64'(bus.sum), 64'(s0));
      chk("hold_cout", 64'(bus.cout), 64'(c0));
      chk("hold_in_ready", 64'(bus.in_ready), 64'h0);
      chk("hold_out_valid", 64'(bus.out_valid), 64'h1);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w, lat;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b0;
    rst_n         = 1'b0;
    @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 64'(bus.in_ready), 64'h1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'h0);
    chk("rst_busy", 64'(bus.busy), 64'h0);
    chk("rst_sum", 64'(bus.sum), 64'h0);
    rst_n = 1'b1;
    @(negedge clk);

    send(16'h0003, 16'h0004, 1'b0, w);
    wait_valid(lat);
    chk("latency", 64'(lat), 64'(NIBBLES));
    take(0, 1'b0, 1'b1, 16'h0007, 1'b0);

    send(16'hFFFF, 16'h0001, 1'b0, w);
    wait_valid(lat);
    take(0, 1'b0, 1'b1, 16'h0000, 1'b1);

    send(16'hAAAA, 16'hFFFF, 1'b1, w);
    wait_valid(lat);
    take(0, 1'b0, 1'b1, 16'hAAAA, 1'b1);
    send(16'h1234, 16'h4321, 1'b1, w);
    chk("b2b_wait", 64'(w), 64'h0);
    wait_valid(lat);
    chk("b2b_latency", 64'(lat), 64'(NIBBLES));
    take(0, 1'b0, 1'b1, 16'h5556, 1'b0);

    // Backpressure with a busy requester toggling operands.
    send(16'h8001, 16'h7FFF, 1'b0, w);
    wait_valid(lat);
    take(3, 1'b1, 1'b1, 16'h0000, 1'b1);

    // Reset in the second RUN cycle, with in_valid and out_ready also asserted.
    send(16'h1111, 16'h2222, 1'b0, w);
    @(posedge clk);
    @(negedge clk);
    rst_n         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_n         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    chk("midrun_rst_in_ready", 64'(bus.in_ready), 64'h1);
    chk("midrun_rst_busy", 64'(bus.busy), 64'h0);
    chk("midrun_rst_out_valid", 64'(bus.out_valid), 64'h0);
    chk("midrun_rst_sum", 64'(bus.sum), 64'h0);
    chk("midrun_rst_cout", 64'(bus.cout), 64'h0);
    repeat (8) @(negedge clk);

    // Reset while DONE is offered and out_ready is high.
    send(16'hF00F, 16'h0FF1, 1'b1, w);
    wait_valid(lat);
    rst_n         = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_n         = 1'b1;
    bus.out_ready = 1'b0;
    chk("done_rst_out_valid", 64'(bus.out_valid), 64'h0);
    chk("done_rst_sum", 64'(bus.sum), 64'h0);
    repeat (3) @(negedge clk);

    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(W'($urandom), W'($urandom), 1'($urandom), w);
      bus.out_ready = 1'($urandom);
      wait_valid(lat);
      chk("rand_latency", 64'(lat), 64'(NIBBLES));
      take(int'($urandom_range(0, 3)), 1'($urandom), 1'b0, '0, 1'b0);
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/nibble_serial_add_ctrl.md
NIBBLE_SERIAL_ADD_CTRL -- requirements
Module: nibble_serial_add_ctrl

Interface
REQ-001 Parameter: NIBBLES, default 4, number of 4-bit slices per operand; operand width W = 4*NIBBLES.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  requester presents an operand pair.
REQ-005 in_ready  output  1  controller can accept an operand pair.
REQ-006 a  input  W  operand A.
REQ-007 b  input  W  operand B.
REQ-008 cin  input  1  carry-in to slice 0.
REQ-009 out_valid  output  1  result held on sum/cout.
REQ-010 out_ready  input  1  consumer takes the result.
REQ-011 sum  output  W  registered result, A+B+cin modulo 2^W.
REQ-012 cout  output  1  registered carry-out of the top slice.
REQ-013 busy  output  1  high in RUN or DONE.

Function
REQ-014 Datapath SHALL be exactly one shared 4-bit ripple adder (a4, b4, cin -> s4, cout4), time-multiplexed across NIBBLES cycles.
REQ-015 FSM states SHALL be IDLE, RUN, DONE; encoding free.
REQ-016 IDLE: in_ready=1, out_valid=0; on in_valid&&in_ready, latch a, b, cin into operand/carry registers, clear sum register, idx=0, go to RUN.
REQ-017 RUN: in_ready=0; each cycle adder inputs = a[idx], b[idx] nibble and carry register; s4 written to sum nibble idx; carry register <= cout4; idx increments.
REQ-018 RUN with idx==NIBBLES-1: after that cycle's update, cout <= cout4, go to DONE.
REQ-019 Latency: acceptance edge = cycle 0; RUN occupies cycles 1..NIBBLES; out_valid first high in cycle NIBBLES+1 (cycle 5 at default).
REQ-020 DONE: out_valid=1; sum and cout SHALL remain stable until out_valid&&out_ready; on that edge go to IDLE, out_valid=0 next cycle.
REQ-021 No new operands SHALL be accepted in RUN or DONE; in_valid there is ignored and a/b changes have no effect on the in-flight result.
REQ-022 Back-to-back: earliest next acceptance is the cycle after the DONE handshake (throughput one result per NIBBLES+2 cycles).
REQ-023 idx counter width SHALL be ceil(log2(NIBBLES)) min 1; no wrap occurs because RUN exits at NIBBLES-1.
REQ-024 Carry SHALL propagate across all slices (e.g. 0xFFFF+0x0001 yields carry through every nibble).
REQ-025 busy = (state != IDLE).

Reset
REQ-026 With rst_n=0 at a rising edge: state=IDLE, idx=0, carry register=0, sum=0, cout=0, out_valid=0, in_ready=1 (from the following cycle).
REQ-027 Reset in any state, including mid-RUN or DONE with out_ready=0, SHALL discard the in-flight operation with no result emitted.
REQ-028 rst_n=0 SHALL dominate in_valid and out_ready in the same cycle.

Structure
REQ-029 Shared package nibble_ctrl_pkg SHALL hold NIBBLE_W=4 and the FSM state typedef.
REQ-030 The 4-bit ripple adder SHALL be instantiated once as sub-module part2 (a, b, cin, s, cout), unmodified; no other arithmetic operators in the controller.

Verification
REQ-031 a=0x0003, b=0x0004, cin=0 -> sum=0x0007, cout=0, out_valid in cycle 5.
REQ-032 a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1 (full carry chain).
REQ-033 a=0xAAAA, b=0xFFFF, cin=1 -> sum=0xAAAA, cout=1; a=0x1234, b=0x4321, cin=1 -> sum=0x5556, cout=0, back-to-back with acceptance one cycle after first handshake.
REQ-034 Backpressure: out_ready=0 for 3 cycles in DONE with in_valid=1 and a/b toggling -> sum/cout stable, in_ready=0, no acceptance.
REQ-035 rst_n=0 in cycle 2 of RUN -> next cycle IDLE, out_valid=0, sum=0, cout=0, busy=0; no result ever presented.
REQ-036 Bench SHALL check every result against a W-bit reference model across all vectors.
